// File: rtl/bram_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bram_stream_reader
//  Description : Reads a block of words from a shared single-port buffer and
//                streams them out on a valid/ready interface. Buffer writes
//                always win the shared port. A 2-entry output FIFO with
//                fall-through bypass sustains one beat per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [ADDR_W:0]   length_in,
    input  logic              wr_enable_in,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic              rd_enable_out,
    input  logic [DATA_W-1:0] rd_data_in,
    input  logic              rd_valid_in,
    output logic [DATA_W-1:0] m_data_out,
    output logic              m_valid_out,
    input  logic              m_ready_in,
    output logic              m_last_out,
    output logic              busy_out,
    output logic              done_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_cnt_zero = '0;
    localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_W:0]   beat_cnt_q, beat_cnt_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic              w_credit;
    logic              w_rd_fire;
    logic              w_in_valid;
    logic              w_head_valid;
    logic              w_m_valid;
    logic [DATA_W-1:0] w_m_data;
    logic              w_pop;
    logic              w_push_fifo;
    logic              w_pop_fifo;
    logic              w_last_pop;

    // Read issue, FIFO bypass and handshake decode
    always_comb begin
        // Credit counts both stored words and the word still coming back
        w_credit     = (count_q + {1'b0, inflight_q}) < 2'd2;
        w_rd_fire    = (state_q == READ) && !wr_enable_in && w_credit;
        // Read data is only trusted when this block issued the read
        w_in_valid   = rd_valid_in && inflight_q && (state_q != IDLE);
        w_head_valid = (count_q != 2'd0);
        w_m_valid    = w_head_valid || w_in_valid;
        w_m_data     = w_head_valid ? fifo_q[rd_ptr_q] : rd_data_in;
        w_pop        = w_m_valid && m_ready_in;
        // An empty FIFO lets incoming data straight through when it is taken
        w_push_fifo  = w_in_valid && !(!w_head_valid && m_ready_in);
        w_pop_fifo   = w_head_valid && m_ready_in;
        w_last_pop   = w_pop && (beat_cnt_q == c_cnt_one);
    end

    // FIFO storage, pointers and occupancy next-state
    always_comb begin
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        if (w_push_fifo) begin
            fifo_d[wr_ptr_q] = rd_data_in;
        end
        wr_ptr_d = wr_ptr_q ^ w_push_fifo;
        rd_ptr_d = rd_ptr_q ^ w_pop_fifo;
        count_d  = count_q + {1'b0, w_push_fifo} - {1'b0, w_pop_fifo};
    end

    // Transfer control FSM: next state, address and counters
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        inflight_d  = w_rd_fire;
        done_d      = 1'b0;

        if (w_pop) begin
            beat_cnt_d = beat_cnt_q - c_cnt_one;
        end

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    if (length_in == c_cnt_zero) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d      = base_addr_in;
                        issue_cnt_d = length_in;
                        beat_cnt_d  = length_in;
                        state_d     = READ;
                    end
                end
            end
            READ: begin
                if (w_rd_fire) begin
                    addr_d      = addr_q + c_addr_one;
                    issue_cnt_d = issue_cnt_q - c_cnt_one;
                    if (issue_cnt_q == c_cnt_one) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_last_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and FIFO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
            fifo_q[0]   <= fifo_d[0];
            fifo_q[1]   <= fifo_d[1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Output drive; stream data is zeroed whenever no beat is offered
    always_comb begin
        rd_enable_out = w_rd_fire;
        rd_addr_out   = addr_q;
        m_valid_out   = w_m_valid;
        m_data_out    = w_m_valid ? w_m_data : '0;
        m_last_out    = w_m_valid && (beat_cnt_q == c_cnt_one);
        busy_out      = (state_q != IDLE);
        done_out      = done_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bram_stream_reader
//  Description : Self-checking bench for bram_stream_reader with a buffer
//                model, transfer-level reference model and directed cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_stream_reader;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_in = 1'b0;
    logic [AW-1:0] base_addr_in = '0;
    logic [AW:0]   length_in = '0;
    logic          wr_enable_in = 1'b0;
    logic [AW-1:0] rd_addr_out;
    logic          rd_enable_out;
    logic [DW-1:0] rd_data_in = '0;
    logic          rd_valid_in = 1'b0;
    logic [DW-1:0] m_data_out;
    logic          m_valid_out;
    logic          m_ready_in = 1'b0;
    logic          m_last_out;
    logic          busy_out;
    logic          done_out;

    bram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_in     (start_in),
        .base_addr_in (base_addr_in),
        .length_in    (length_in),
        .wr_enable_in (wr_enable_in),
        .rd_addr_out  (rd_addr_out),
        .rd_enable_out(rd_enable_out),
        .rd_data_in   (rd_data_in),
        .rd_valid_in  (rd_valid_in),
        .m_data_out   (m_data_out),
        .m_valid_out  (m_valid_out),
        .m_ready_in   (m_ready_in),
        .m_last_out   (m_last_out),
        .busy_out     (busy_out),
        .done_out     (done_out)
    );

    always #5 clk = ~clk;

    // Buffer content is a fixed function of the address
    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // Buffer model: data and valid exactly one cycle after the read strobe
    always @(posedge clk) begin
        rd_valid_in <= rd_enable_out;
        rd_data_in  <= memf(rd_addr_out);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model state (transfer level)
    bit            m_busy = 0;
    bit            m_done = 0;
    logic [AW-1:0] m_base = '0;
    int            m_len = 0;
    int            m_reads = 0;
    int            m_beats = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] exp_daddr;

    int            rel = 0;
    logic [AW-1:0] rd_log[$];
    int            beat_rel[$];
    int            done_rel = -1;

    // Stimulus knobs
    int rdy_pct = 100;
    int wr_pct  = 0;
    int rl_lo = 1000, rl_hi = -1;
    int wl_lo = 1000, wl_hi = -1;

    // Compare process: checks every cycle mid-period, then advances the model
    always @(negedge clk) begin
        bit nbusy;
        bit ndone;
        if (!rst_n) begin
            chk("rst_rd_en", rd_enable_out, 0);
            chk("rst_rd_addr", rd_addr_out, 0);
            chk("rst_m_valid", m_valid_out, 0);
            chk("rst_m_data", m_data_out, 0);
            chk("rst_m_last", m_last_out, 0);
            chk("rst_busy", busy_out, 0);
            chk("rst_done", done_out, 0);
            m_busy     = 0;
            m_done     = 0;
            prev_stall = 0;
        end else begin
            nbusy = m_busy;
            ndone = 0;
            chk("busy", busy_out, m_busy);
            chk("done", done_out, m_done);
            if (wr_enable_in) chk("rd_en_during_write", rd_enable_out, 0);
            if (rd_enable_out) begin
                exp_addr = m_base + AW'(m_reads);
                chk("rd_in_transfer", (m_busy && m_reads < m_len), 1);
                chk("rd_addr", rd_addr_out, exp_addr);
                rd_log.push_back(rd_addr_out);
            end
            if (prev_stall) begin
                chk("hold_valid", m_valid_out, 1);
                chk("hold_data", m_data_out, prev_data);
            end
            if (m_valid_out) begin
                exp_daddr = m_base + AW'(m_beats);
                chk("beat_in_transfer", (m_busy && m_beats < m_len), 1);
                chk("m_data", m_data_out, memf(exp_daddr));
                chk("m_last", m_last_out, (m_beats == m_len - 1));
            end else begin
                chk("last_without_valid", m_last_out, 0);
            end
            if (rd_enable_out) m_reads++;
            if (m_valid_out && m_ready_in) begin
                beat_rel.push_back(rel);
                m_beats++;
                if (m_beats == m_len) begin
                    nbusy = 0;
                    ndone = 1;
                end
            end
            if (m_busy) chk("reads_ahead_le2", ((m_reads - m_beats) <= 2), 1);
            if (start_in && !m_busy) begin
                if (length_in == 0) begin
                    ndone = 1;
                end else begin
                    nbusy   = 1;
                    m_base  = base_addr_in;
                    m_len   = int'(length_in);
                    m_reads = 0;
                    m_beats = 0;
                end
            end
            prev_stall = m_valid_out && !m_ready_in;
            prev_data  = m_data_out;
            m_busy     = nbusy;
            m_done     = ndone;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rel++;
        start_in     = 1'b0;
        m_ready_in   = (rel >= rl_lo && rel <= rl_hi) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        wr_enable_in = (rel >= wl_lo && rel <= wl_hi) ? 1'b1 : ($urandom_range(0, 99) < wr_pct);
    endtask

    task automatic run(input logic [AW-1:0] base, input int len, input int dup_at, input int stop_beats);
        bit got_done;
        step();
        rel = 0;
        rd_log.delete();
        beat_rel.delete();
        done_rel     = -1;
        got_done     = 0;
        start_in     = 1'b1;
        base_addr_in = base;
        length_in    = len[AW:0];
        for (int i = 0; i < 400; i++) begin
            step();
            if (done_out) begin
                done_rel = rel;
                got_done = 1;
                break;
            end
            if (rel == dup_at) begin
                start_in     = 1'b1;
                base_addr_in = base + 16'h0100;
                length_in    = 17'd3;
            end
            if (stop_beats > 0 && beat_rel.size() >= stop_beats) return;
        end
        chk("done_seen", got_done, 1);
        chk("n_reads", rd_log.size(), len);
        chk("n_beats", beat_rel.size(), len);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic transfer: consecutive reads, first beat 2 cycles after start
        run(16'h0010, 4, -1, 0);
        chk("p039_addr0", rd_log[0], 16'h0010);
        chk("p039_addr3", rd_log[3], 16'h0013);
        chk("p039_first_beat", beat_rel[0], 2);
        chk("p039_last_beat", beat_rel[3], 5);
        chk("p039_done", done_rel, 6);

        // Address wrap
        run(16'hFFFE, 4, -1, 0);
        chk("p040_a0", rd_log[0], 16'hFFFE);
        chk("p040_a1", rd_log[1], 16'hFFFF);
        chk("p040_a2", rd_log[2], 16'h0000);
        chk("p040_a3", rd_log[3], 16'h0001);

        // Backpressure
        rl_lo = 3; rl_hi = 7;
        run(16'h0040, 8, -1, 0);
        rl_lo = 1000; rl_hi = -1;
        chk("p041_beat1", beat_rel[1], 8);
        chk("p041_done", done_rel, 15);

        // Write steals the port for 3 cycles
        wl_lo = 3; wl_hi = 5;
        run(16'h1234, 8, -1, 0);
        wl_lo = 1000; wl_hi = -1;
        chk("p042_a2", rd_log[2], 16'h1236);
        chk("p042_a7", rd_log[7], 16'h123B);
        chk("p042_done", done_rel, 13);

        // Zero length, then a start while busy
        run(16'h0500, 0, -1, 0);
        chk("p043_done", done_rel, 1);
        run(16'h0200, 4, 2, 0);
        chk("p043_dup_a0", rd_log[0], 16'h0200);

        // Reset mid-transfer
        run(16'h0300, 6, -1, 2);
        rst_n = 1'b0;
        #1;
        chk("p044_valid", m_valid_out, 0);
        chk("p044_busy", busy_out, 0);
        chk("p044_rd_en", rd_enable_out, 0);
        chk("p044_addr", rd_addr_out, 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("p044_no_more_beats", beat_rel.size(), 2);

        // Randomized transfers
        rdy_pct = 70;
        wr_pct  = 25;
        for (int t = 0; t < 25; t++) begin
            logic [AW-1:0] b;
            int            l;
            b = ($urandom_range(0, 9) < 3) ? (16'hFFF8 + AW'($urandom_range(0, 7))) : AW'($urandom);
            l = $urandom_range(0, 12);
            run(b, l, $urandom_range(1, 5), 0);
        end
        rdy_pct = 100;
        wr_pct  = 0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
